// File: rtl/srv6_pkg.sv
// Shared definitions for the SRv6 ingress arbiter.
//   BEAT_W      : width of one data beat on every ingress port and on the output
//   arb_state_t : arbiter FSM state encoding (StIdle, StStream, StDrain, StGap)
package srv6_pkg;

    localparam int unsigned BEAT_W = 512;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t StIdle   = 2'd0;
    localparam arb_state_t StStream = 2'd1;
    localparam arb_state_t StDrain  = 2'd2;
    localparam arb_state_t StGap    = 2'd3;

endpackage

// File: rtl/srv6_ingress_arbiter_rr_arbiter.sv
// Combinational round-robin winner selection.
//   req     : request vector, one bit per port
//   ptr     : index of the last granted port; the search starts at ptr+1 and wraps
//   gnt     : one-hot grant (all zero when nothing requests)
//   gnt_idx : binary index of the granted port (0 when nothing requests)
module rr_arbiter #(
    parameter int unsigned NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]         req,
    input  logic [$clog2(NUM_PORTS)-1:0] ptr,
    output logic [NUM_PORTS-1:0]         gnt,
    output logic [$clog2(NUM_PORTS)-1:0] gnt_idx
);

    localparam int unsigned IdxW = $clog2(NUM_PORTS);

    int unsigned cand;
    logic        found;

    // Walk ptr+1 .. ptr+NUM_PORTS (mod NUM_PORTS); the first requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            cand = (32'(ptr) + i) % NUM_PORTS;
            if (!found && req[cand[IdxW-1:0]]) begin
                found                = 1'b1;
                gnt[cand[IdxW-1:0]]  = 1'b1;
                gnt_idx              = cand[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/srv6_ingress_arbiter.sv
// Packet-level round-robin arbiter feeding the SRv6 processor from NUM_PORTS
// ingress streams. A port keeps the grant for a whole packet; packets longer than
// MAX_BEATS are truncated (remaining beats drained), and GAP_CYCLES idle cycles
// are forced between packets.
//   clk, reset   : clock and synchronous active-high reset
//   in_data      : NUM_PORTS beats, port p at [p*512 +: 512]
//   in_valid     : per-port beat valid
//   in_last      : per-port final beat of packet
//   in_ready     : per-port accept, only ever set for the granted port
//   out_data     : forwarded beat, one cycle after acceptance
//   out_valid    : forwarded beat valid
//   out_port     : currently granted port
//   busy         : FSM is not idle
//   pkt_done     : pulse when a packet's last beat was accepted
//   err_overlong : pulse when a packet was truncated at MAX_BEATS
module srv6_ingress_arbiter
    import srv6_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned MAX_BEATS  = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_PORTS*BEAT_W-1:0]  in_data,
    input  logic [NUM_PORTS-1:0]         in_valid,
    input  logic [NUM_PORTS-1:0]         in_last,
    output logic [NUM_PORTS-1:0]         in_ready,
    output logic [BEAT_W-1:0]            out_data,
    output logic                         out_valid,
    output logic [$clog2(NUM_PORTS)-1:0] out_port,
    output logic                         busy,
    output logic                         pkt_done,
    output logic                         err_overlong
);

    localparam int unsigned PortW = $clog2(NUM_PORTS);
    localparam int unsigned CntW  = $clog2(MAX_BEATS + 1);
    localparam int unsigned GapW  = 4;

    arb_state_t              state_q, state_d;
    logic [PortW-1:0]        port_q, port_d;
    logic [PortW-1:0]        ptr_q, ptr_d;
    logic [CntW-1:0]         beat_q, beat_d;
    logic [GapW-1:0]         gap_q, gap_d;
    logic                    out_valid_q, out_valid_d;
    logic [BEAT_W-1:0]       out_data_q, out_data_d;
    logic                    pkt_done_q, pkt_done_d;
    logic                    err_q, err_d;

    logic [NUM_PORTS-1:0]    arb_gnt;
    logic [PortW-1:0]        arb_idx;
    logic [BEAT_W-1:0]       port_beat [NUM_PORTS];
    logic                    sel_valid;
    logic                    sel_last;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_beat
        assign port_beat[p] = in_data[p*BEAT_W +: BEAT_W];
    end

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign sel_valid = in_valid[port_q];
    assign sel_last  = in_last[port_q];

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        ptr_d       = ptr_q;
        beat_d      = beat_q;
        gap_d       = gap_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        pkt_done_d  = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|arb_gnt) begin
                    state_d = StStream;
                    port_d  = arb_idx;
                    ptr_d   = arb_idx;
                    beat_d  = '0;
                end
            end
            StStream, StDrain: begin
                if (sel_valid) begin
                    // Saturate while draining so an arbitrarily long tail cannot wrap.
                    if (beat_q != CntW'(MAX_BEATS)) begin
                        beat_d = beat_q + CntW'(1);
                    end
                    if (state_q == StStream) begin
                        out_valid_d = 1'b1;
                        out_data_d  = port_beat[port_q];
                    end
                    // in_last wins over truncation: a packet of exactly MAX_BEATS is legal.
                    if (sel_last) begin
                        pkt_done_d = 1'b1;
                        if (GAP_CYCLES == 0) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StGap;
                            gap_d   = GapW'(GAP_CYCLES);
                        end
                    end else if (state_q == StStream && beat_q == CntW'(MAX_BEATS - 1)) begin
                        err_d   = 1'b1;
                        state_d = StDrain;
                    end
                end
            end
            StGap: begin
                if (gap_q <= GapW'(1)) begin
                    state_d = StIdle;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            port_q      <= '0;
            ptr_q       <= PortW'(NUM_PORTS - 1);
            beat_q      <= '0;
            gap_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            pkt_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            ptr_q       <= ptr_d;
            beat_q      <= beat_d;
            gap_q       <= gap_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            pkt_done_q  <= pkt_done_d;
            err_q       <= err_d;
        end
    end

    // Ready depends only on state so a source may wait for it before raising valid.
    always_comb begin
        in_ready = '0;
        if (state_q == StStream || state_q == StDrain) begin
            in_ready[port_q] = 1'b1;
        end
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign out_port     = port_q;
    assign busy         = (state_q != StIdle);
    assign pkt_done     = pkt_done_q;
    assign err_overlong = err_q;

endmodule

// File: tb/tb_srv6_ingress_arbiter.sv
module tb_srv6_ingress_arbiter;

    localparam int NP   = 4;
    localparam int GAP  = 4;
    localparam int MAXB = 64;
    localparam int BW   = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (default parameters)
    logic              reset;
    logic [NP*BW-1:0]  in_data;
    logic [NP-1:0]     in_valid, in_last, in_ready;
    logic [BW-1:0]     out_data;
    logic              out_valid;
    logic [1:0]        out_port;
    logic              busy, pkt_done, err_overlong;

    srv6_ingress_arbiter #(
        .NUM_PORTS  (NP),
        .GAP_CYCLES (GAP),
        .MAX_BEATS  (MAXB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_port     (out_port),
        .busy         (busy),
        .pkt_done     (pkt_done),
        .err_overlong (err_overlong)
    );

    // Second DUT with no inter-packet gap
    logic              g_reset = 1'b1;
    logic [2*BW-1:0]   g_data = '0;
    logic [1:0]        g_valid = '0, g_last = '0, g_ready;
    logic [BW-1:0]     g_out_data;
    logic              g_out_valid, g_out_port, g_busy, g_pkt_done, g_err;

    srv6_ingress_arbiter #(
        .NUM_PORTS  (2),
        .GAP_CYCLES (0),
        .MAX_BEATS  (4)
    ) dut_g (
        .clk          (clk),
        .reset        (g_reset),
        .in_data      (g_data),
        .in_valid     (g_valid),
        .in_last      (g_last),
        .in_ready     (g_ready),
        .out_data     (g_out_data),
        .out_valid    (g_out_valid),
        .out_port     (g_out_port),
        .busy         (g_busy),
        .pkt_done     (g_pkt_done),
        .err_overlong (g_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: which port owns the output, how many beats it has sent,
    // whether it is being discarded, and how many gap cycles remain.
    bit            m_active = 0, m_drain = 0;
    int            m_gap = 0, m_port = 0, m_ptr = NP - 1, m_beats = 0;
    logic [BW-1:0] e_data = '0;
    bit            e_valid = 0, e_done = 0, e_err = 0;

    // Sources: beats left in the current packet, stall cycles, beats accepted
    int len[NP], stall[NP], acc_cnt[NP];
    int mode = 0;          // 0 directed, 1 endless 1-beat packets, 2 random
    bit rst_req = 1;

    // Observations of the DUT for the literal checks
    int n_valid, n_done, n_err, n_gap, cyc, err_at, done_at;
    int valid_at[$];
    int grants[$];
    bit prev_busy = 0, r3_seen = 0;

    function automatic logic [NP-1:0] model_ready();
        return m_active ? NP'(1 << m_port) : '0;
    endfunction

    task automatic model_update();
        if (reset) begin
            m_active = 0; m_drain = 0; m_gap = 0; m_port = 0; m_ptr = NP - 1; m_beats = 0;
            e_data = '0; e_valid = 0; e_done = 0; e_err = 0;
        end else begin
            e_valid = 0; e_done = 0; e_err = 0;
            if (m_gap > 0) begin
                m_gap--;
            end else if (!m_active) begin
                for (int i = 1; i <= NP; i++) begin
                    int c;
                    c = (m_ptr + i) % NP;
                    if (!m_active && in_valid[c]) begin
                        m_active = 1; m_drain = 0; m_port = c; m_ptr = c; m_beats = 0;
                    end
                end
            end else if (in_valid[m_port]) begin
                m_beats++;
                if (!m_drain) begin
                    e_valid = 1;
                    e_data  = in_data[m_port*BW +: BW];
                end
                if (in_last[m_port]) begin
                    e_done   = 1;
                    m_active = 0;
                    m_gap    = GAP;
                end else if (!m_drain && m_beats == MAXB) begin
                    e_err   = 1;
                    m_drain = 1;
                end
            end
        end
    endtask

    task automatic clear_stats();
        n_valid = 0; n_done = 0; n_err = 0; n_gap = 0; cyc = 0; err_at = -1; done_at = -1;
        valid_at.delete();
        grants.delete();
        r3_seen = 0;
        for (int p = 0; p < NP; p++) acc_cnt[p] = 0;
    endtask

    // One clock: drive inputs, advance model, compare every output.
    task automatic step();
        logic [NP-1:0] acc;
        if (mode == 2) begin
            rst_req = ($urandom_range(399) == 0);
            for (int p = 0; p < NP; p++) begin
                if (len[p] == 0 && $urandom_range(3) == 0)
                    len[p] = ($urandom_range(19) == 0) ? 60 + $urandom_range(14) : 1 + $urandom_range(5);
                if (stall[p] == 0 && $urandom_range(7) == 0)
                    stall[p] = 1 + $urandom_range(2);
            end
        end
        for (int p = 0; p < NP; p++) begin
            in_valid[p] = (len[p] > 0) && (stall[p] == 0);
            in_last[p]  = (len[p] == 1);
        end
        for (int w = 0; w < NP * BW / 32; w++) in_data[w*32 +: 32] = $urandom;
        reset = rst_req;
        acc   = model_ready() & in_valid;
        @(posedge clk);
        model_update();
        for (int p = 0; p < NP; p++) begin
            if (rst_req) begin
                len[p] = 0; stall[p] = 0;
            end else begin
                if (acc[p]) begin len[p]--; acc_cnt[p]++; end
                if (stall[p] > 0) stall[p]--;
                if (mode == 1 && len[p] == 0) len[p] = 1;
            end
        end
        #1;
        chk("out_valid", out_valid, e_valid);
        chk("out_data", out_data, e_data);
        chk("out_port", out_port, m_port);
        chk("busy", busy, m_active || m_gap > 0);
        chk("pkt_done", pkt_done, e_done);
        chk("err_overlong", err_overlong, e_err);
        chk("in_ready", in_ready, model_ready());
        if (in_ready[3] && n_done == 0) r3_seen = 1;
        if (out_valid) begin n_valid++; valid_at.push_back(cyc); end
        if (pkt_done) begin n_done++; done_at = cyc; end
        if (err_overlong) begin n_err++; err_at = cyc; end
        if (busy && in_ready == '0) n_gap++;
        if (busy && !prev_busy) grants.push_back(int'(out_port));
        prev_busy = busy;
        cyc++;
    endtask

    task automatic do_reset();
        mode = 0;
        rst_req = 1;
        for (int p = 0; p < NP; p++) begin len[p] = 0; stall[p] = 0; end
        step();
        step();
        chk("rst busy", busy, 0);
        chk("rst out_port", out_port, 0);
        chk("rst in_ready", in_ready, 0);
        chk("rst out_data", out_data, 0);
        rst_req = 0;
        clear_stats();
    endtask

    logic [3:0]    g_exp_busy  = 4'b0101;
    logic [3:0]    g_exp_valid = 4'b1010;
    logic [BW-1:0] g_sent;
    bit            stalled;

    initial begin
        for (int p = 0; p < NP; p++) begin len[p] = 0; stall[p] = 0; acc_cnt[p] = 0; end
        in_valid = '0; in_last = '0; in_data = '0; reset = 1;

        // 3-beat packet on port 2 alone
        do_reset();
        len[2] = 3;
        for (int k = 0; k < 12; k++) step();
        chk("A beats", n_valid, 3);
        chk("A pkt_done", n_done, 1);
        chk("A grants", grants.size(), 1);
        chk("A port", grants.size() > 0 ? grants[0] : -1, 2);
        chk("A first beat cycle", valid_at.size() > 0 ? valid_at[0] : -1, 1);
        chk("A consecutive", valid_at.size() > 2 ? valid_at[2] - valid_at[0] : -1, 2);
        chk("A gap cycles", n_gap, 4);

        // All ports always requesting 1-beat packets
        do_reset();
        mode = 1;
        for (int p = 0; p < NP; p++) len[p] = 1;
        for (int k = 0; k < 200 && grants.size() < 5; k++) step();
        mode = 0;
        chk("B grant count", grants.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("B grant %0d", i), grants.size() > i ? grants[i] : -1, i % NP);
        for (int i = 1; i < 4; i++)
            chk($sformatf("B spacing %0d", i),
                valid_at.size() > i ? valid_at[i] - valid_at[i-1] : -1, GAP + 2);

        // 70-beat packet on port 1 gets truncated to 64
        do_reset();
        len[1] = 70;
        for (int k = 0; k < 200 && n_done == 0; k++) step();
        step();
        chk("C forwarded", n_valid, 64);
        chk("C err count", n_err, 1);
        chk("C err cycle", err_at, 64);
        chk("C done count", n_done, 1);
        chk("C done cycle", done_at, 70);
        chk("C accepted", acc_cnt[1], 70);

        // Port 0 stalls mid-packet while port 3 waits
        do_reset();
        len[0] = 6;
        len[3] = 2;
        stalled = 0;
        for (int k = 0; k < 100 && n_done < 2; k++) begin
            step();
            if (acc_cnt[0] == 2 && !stalled) begin stall[0] = 5; stalled = 1; end
        end
        chk("D done count", n_done, 2);
        chk("D port3 ready early", r3_seen, 0);
        chk("D port0 beats", acc_cnt[0], 6);
        chk("D port3 beats", acc_cnt[3], 2);
        chk("D first grant", grants.size() > 0 ? grants[0] : -1, 0);
        chk("D second grant", grants.size() > 1 ? grants[1] : -1, 3);

        // Reset during beat 2 of a 4-beat packet
        do_reset();
        len[2] = 4;
        for (int k = 0; k < 20 && acc_cnt[2] < 1; k++) step();
        rst_req = 1;
        step();
        rst_req = 0;
        chk("E in_ready", in_ready, 0);
        chk("E out_valid", out_valid, 0);
        chk("E busy", busy, 0);
        clear_stats();
        len[0] = 1;
        len[2] = 1;
        for (int k = 0; k < 20 && grants.size() == 0; k++) step();
        chk("E next grant", grants.size() > 0 ? grants[0] : -1, 0);

        // Random traffic
        do_reset();
        mode = 2;
        for (int k = 0; k < 3000; k++) step();
        mode = 0;

        // Zero-gap instance: back-to-back 1-beat packets on port 0
        @(posedge clk);
        @(posedge clk);
        #1;
        g_reset = 0;
        g_valid = 2'b01;
        g_last  = 2'b01;
        g_sent  = '0;
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 2 * BW / 32; w++) g_data[w*32 +: 32] = $urandom;
            if (k == 1) g_sent = g_data[BW-1:0];
            @(posedge clk);
            #1;
            chk($sformatf("F busy %0d", k), g_busy, g_exp_busy[k]);
            chk($sformatf("F out_valid %0d", k), g_out_valid, g_exp_valid[k]);
            chk($sformatf("F pkt_done %0d", k), g_pkt_done, g_exp_valid[k]);
            chk($sformatf("F port %0d", k), g_out_port, 0);
            if (k == 1) chk("F out_data", g_out_data, g_sent);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/srv6_ingress_arbiter.md
SRV6_INGRESS_ARBITER -- requirements
Module: srv6_ingress_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of requesting ingress ports (2..8).
REQ-002 SHALL have parameter GAP_CYCLES, default 4: idle cycles forced between packets (0..15).
REQ-003 SHALL have parameter MAX_BEATS, default 64: maximum forwarded beats per packet, equal to the packet buffer word count.
REQ-004 SHALL have port clk, input, 1: the single clock for all logic.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_data, input, NUM_PORTS*512: beat per port; port p occupies bits [p*512+511 : p*512].
REQ-007 SHALL have port in_valid, input, NUM_PORTS: per-port beat valid.
REQ-008 SHALL have port in_last, input, NUM_PORTS: per-port final beat of packet.
REQ-009 SHALL have port in_ready, output, NUM_PORTS: per-port beat accept; combinational from state, not from in_valid.
REQ-010 SHALL have port out_data, output, 512: beat to the SRv6 processor din.
REQ-011 SHALL have port out_valid, output, 1: drives the SRv6 processor valid.
REQ-012 SHALL have port out_port, output, clog2(NUM_PORTS): currently granted port.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port pkt_done, output, 1: one-cycle pulse when a packet's last beat is accepted.
REQ-015 SHALL have port err_overlong, output, 1: one-cycle pulse when a packet is truncated.

Function
REQ-016 SHALL implement states IDLE, STREAM, DRAIN and GAP.
REQ-017 IDLE: in_ready all 0; if any in_valid is set, SHALL register the round-robin winner into out_port and go to STREAM next cycle.
REQ-018 Round-robin: search starts at (last granted + 1) mod NUM_PORTS, ascending with wrap; the pointer updates on grant only.
REQ-019 STREAM: in_ready[out_port] = 1 and all other ready bits = 0; a beat is accepted when in_valid[out_port] & in_ready[out_port].
REQ-020 An accepted beat SHALL appear on out_data with out_valid=1 exactly 1 cycle later; otherwise out_valid=0 and out_data holds its previous value.
REQ-021 SHALL keep a beat counter cleared on grant and incremented per accepted beat, wide enough to hold MAX_BEATS.
REQ-022 If the accepted beat has in_last=1, SHALL pulse pkt_done and go to GAP, or to IDLE when GAP_CYCLES=0.
REQ-023 If the accepted beat is number MAX_BEATS and in_last=0, SHALL forward that beat, pulse err_overlong, and go to DRAIN.
REQ-024 DRAIN: in_ready[out_port] = 1 and out_valid = 0; beats are discarded until in_last is accepted, which pulses pkt_done and goes to GAP/IDLE as in REQ-022.
REQ-025 GAP: counter loads GAP_CYCLES on entry; out_valid = 0; in_ready all 0; goes to IDLE after exactly GAP_CYCLES cycles in GAP.
REQ-026 Non-granted ports SHALL never see in_ready=1; a granted port de-asserting in_valid mid-packet SHALL hold the grant indefinitely (no timeout).
REQ-027 A packet with in_last on its first beat SHALL be a legal 1-beat packet.
REQ-028 Requests arriving during GAP SHALL be ignored until IDLE; in that IDLE cycle, arbitration uses the current in_valid.

Reset
REQ-029 On reset: state = IDLE, out_valid = 0, out_data = 0, out_port = 0, pkt_done = 0, err_overlong = 0, counters = 0, and the rr pointer = NUM_PORTS-1 so that port 0 wins first.
REQ-030 Reset asserted mid-packet SHALL abandon the packet immediately; in_ready SHALL be 0 on the cycle after reset is sampled.

Structure
REQ-031 Package srv6_pkg SHALL hold BEAT_W=512 and the arbiter state enum.
REQ-032 Winner selection SHALL be a sub-module rr_arbiter (request vector and pointer in, one-hot grant and index out, combinational).

Verification
REQ-033 Port 2 only, 3-beat packet (last on beat 3) -> out_valid high for 3 consecutive cycles, each 1 cycle after acceptance; pkt_done pulses once; out_port=2; then 4 idle GAP cycles.
REQ-034 All 4 ports valid continuously with 1-beat packets, after reset -> grant order 0,1,2,3,0; each packet separated by GAP_CYCLES+1 cycles of out_valid=0.
REQ-035 Port 1 sends a 70-beat packet -> 64 beats forwarded, err_overlong pulses after beat 64, beats 65..70 accepted but not forwarded, pkt_done on beat 70.
REQ-036 Port 0 drops in_valid for 5 cycles mid-packet while port 3 is valid -> port 3 in_ready stays 0; port 0 resumes and completes; port 3 is granted next.
REQ-037 reset asserted on beat 2 of a 4-beat packet -> next cycle: in_ready=0, out_valid=0, busy=0; the next grant goes to port 0.
REQ-038 GAP_CYCLES=0 with back-to-back 1-beat packets on port 0 -> a new grant in the IDLE cycle immediately after the last beat.
